// File: rtl/syscall_pkg.sv
// Shared syscall codes, FSM state encoding and decimal powers for the console unit.
package syscall_pkg;

  localparam logic [31:0] SYSCALL_PRINT_INT = 32'd1;
  localparam logic [31:0] SYSCALL_PRINT_STR = 32'd4;
  localparam logic [31:0] SYSCALL_EXIT      = 32'd10;

  typedef enum logic [2:0] {
    IDLE,
    INT_SIGN,
    INT_DIGIT,
    INT_EMIT,
    STR_RD,
    STR_WAIT,
    STR_EMIT,
    HALTED
  } state_t;

  // POW10[i] = 10^i
  localparam logic [31:0] POW10 [0:9] = '{
    32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
    32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
  };

endpackage

// File: rtl/syscall_console_if.sv
// CPU request, data-memory read port and character stream of the syscall console.
interface syscall_console_if #(
  parameter int DM_ADDR_W = 16
);
  logic                 req_valid;
  logic [31:0]          req_code;
  logic [31:0]          req_arg;
  logic                 busy;
  logic                 mem_rd_en;
  logic [DM_ADDR_W-1:0] mem_addr;
  logic [31:0]          mem_rdata;
  logic                 char_valid;
  logic [7:0]           char_data;
  logic                 char_ready;
  logic                 halt;
  logic                 err_invalid;

  modport master (
    output req_valid, req_code, req_arg, mem_rdata, char_ready,
    input  busy, mem_rd_en, mem_addr, char_valid, char_data, halt, err_invalid
  );

  modport slave (
    input  req_valid, req_code, req_arg, mem_rdata, char_ready,
    output busy, mem_rd_en, mem_addr, char_valid, char_data, halt, err_invalid
  );
endinterface

// File: rtl/dec_serializer.sv
// Signed 32-bit to ASCII decimal by repeated subtraction; one subtract per cycle.
// Characters leave on a registered valid/ready stream; done pulses with the last handshake.
module dec_serializer
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        out_vld,
  output logic [7:0]  out_dat,
  input  logic        out_rdy,
  output logic        done
);

  state_t      st_q, st_d;
  logic [31:0] mag_q, mag_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  digit_q, digit_d;
  logic        started_q, started_d;
  logic        sign_q, sign_d;
  logic        vld_q, vld_d;
  logic [7:0]  chr_q, chr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      mag_q     <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      started_q <= 1'b0;
      sign_q    <= 1'b0;
      vld_q     <= 1'b0;
      chr_q     <= '0;
    end else begin
      st_q      <= st_d;
      mag_q     <= mag_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      started_q <= started_d;
      sign_q    <= sign_d;
      vld_q     <= vld_d;
      chr_q     <= chr_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    mag_d     = mag_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    started_d = started_q;
    sign_d    = sign_q;
    vld_d     = vld_q;
    chr_d     = chr_q;
    done      = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) begin
          mag_d = value;
          st_d  = INT_SIGN;
        end
      end
      INT_SIGN: begin
        idx_d     = 4'd9;
        digit_d   = 4'd0;
        started_d = 1'b0;
        if (mag_q[31]) begin
          // unsigned view of the negation: 0x80000000 stays 2147483648
          mag_d  = ~mag_q + 32'd1;
          chr_d  = 8'h2D;
          vld_d  = 1'b1;
          sign_d = 1'b1;
          st_d   = INT_EMIT;
        end else begin
          st_d = INT_DIGIT;
        end
      end
      INT_DIGIT: begin
        if (mag_q >= POW10[idx_q]) begin
          mag_d   = mag_q - POW10[idx_q];
          digit_d = digit_q + 4'd1;
        end else if (digit_q != 4'd0 || started_q || idx_q == 4'd0) begin
          chr_d = 8'h30 + {4'h0, digit_q};
          vld_d = 1'b1;
          st_d  = INT_EMIT;
        end else begin
          idx_d = idx_q - 4'd1;
        end
      end
      INT_EMIT: begin
        if (vld_q && out_rdy) begin
          vld_d = 1'b0;
          if (sign_q) begin
            sign_d = 1'b0;
            st_d   = INT_DIGIT;
          end else if (idx_q == 4'd0) begin
            done = 1'b1;
            st_d = IDLE;
          end else begin
            idx_d     = idx_q - 4'd1;
            digit_d   = 4'd0;
            started_d = 1'b1;
            st_d      = INT_DIGIT;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign out_vld = vld_q;
  assign out_dat = chr_q;

endmodule

// File: rtl/syscall_console.sv
// SYSCALL service unit: print_int, print_string (byte-wise memory walk) and exit.
// Holds busy while a request runs; character output stalls on char_ready.
module syscall_console
  import syscall_pkg::*;
#(
  parameter int DM_ADDR_W   = 16,
  parameter int MAX_STR_LEN = 1024
) (
  input logic              clk,
  input logic              rst,
  syscall_console_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

  state_t               state_q, state_d;
  logic [DM_ADDR_W+1:0] baddr_q, baddr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           chr_q, chr_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic                 accept, ser_start, ser_vld, ser_done;
  logic [7:0]           ser_dat, lane;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign ser_start = accept && (bus.req_code == SYSCALL_PRINT_INT);

  dec_serializer u_dec (
    .clk     (clk),
    .rst     (rst),
    .start   (ser_start),
    .value   (bus.req_arg),
    .out_vld (ser_vld),
    .out_dat (ser_dat),
    .out_rdy (bus.char_ready),
    .done    (ser_done)
  );

  always_comb begin
    lane = bus.mem_rdata[7:0];
    case (baddr_q[1:0])
      2'd1:    lane = bus.mem_rdata[15:8];
      2'd2:    lane = bus.mem_rdata[23:16];
      2'd3:    lane = bus.mem_rdata[31:24];
      default: lane = bus.mem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baddr_q <= '0;
      cnt_q   <= '0;
      chr_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // INT_SIGN stands for the whole print_int run; the serializer owns the digit states.
  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.req_code == SYSCALL_PRINT_INT) begin
            state_d = INT_SIGN;
          end else if (bus.req_code == SYSCALL_PRINT_STR) begin
            baddr_d = bus.req_arg[DM_ADDR_W+1:0];
            cnt_d   = '0;
            state_d = STR_RD;
          end else if (bus.req_code == SYSCALL_EXIT) begin
            state_d = HALTED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      INT_SIGN: begin
        if (ser_done) state_d = IDLE;
      end
      STR_RD: state_d = STR_WAIT;
      STR_WAIT: begin
        if (lane == 8'h00) begin
          state_d = IDLE;
        end else begin
          chr_d   = lane;
          vld_d   = 1'b1;
          state_d = STR_EMIT;
        end
      end
      STR_EMIT: begin
        if (vld_q && bus.char_ready) begin
          vld_d   = 1'b0;
          baddr_d = baddr_q + (DM_ADDR_W+2)'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(MAX_STR_LEN)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STR_RD;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.halt        = (state_q == HALTED);
  assign bus.mem_rd_en   = (state_q == STR_RD);
  assign bus.mem_addr    = baddr_q[DM_ADDR_W+1:2];
  assign bus.char_valid  = (state_q == INT_SIGN) ? ser_vld : vld_q;
  assign bus.char_data   = (state_q == INT_SIGN) ? ser_dat : chr_q;
  assign bus.err_invalid = err_q;

endmodule
